// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: constant log2 and power-of-2 test.
package mux_tree_pipe_pkg;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // True for 2, 4, 8, ... (1 is rejected: a tree needs at least one level).
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered 2:1 tree level: halves the channel vector using the tag bit
// that belongs to this level, and forwards the full select tag and valid.
module mux_tree_stage
  import mux_tree_pipe_pkg::*;
#(
  parameter int IN_CNT = 2,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_CNT-1:0][DATA_W-1:0]    in_vec,
  input  logic [SEL_W-1:0]                 in_tag,
  input  logic                             in_valid,
  output logic [IN_CNT/2-1:0][DATA_W-1:0]  out_vec,
  output logic [SEL_W-1:0]                 out_tag,
  output logic                             out_valid
);

  // Level index follows from how many channels are still left: the first
  // level sees N_IN channels and consumes tag bit 0.
  localparam int LVL = SEL_W - clog2(IN_CNT);

  logic [IN_CNT/2-1:0][DATA_W-1:0] nxt_vec;

  // Pair j keeps element 2j+1 when this level's tag bit is set, else 2j.
  always_comb begin
    nxt_vec = '0;
    for (int j = 0; j < IN_CNT/2; j++)
      nxt_vec[j] = in_tag[LVL] ? in_vec[2*j+1] : in_vec[2*j];
  end

  // Level register; bubbles still load data, only valid marks it as junk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec   <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_vec   <= nxt_vec;
      out_tag   <= in_tag;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux tree, one register per level, with a select tag that
// travels alongside the data and an optional auto-scan select source.
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 1,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  input  logic                     scan_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         scan_ptr
);

  if (!is_pow2(N_IN)) begin : g_bad_n_in
    $error("mux_tree_pipe: N_IN=%0d is not a power of 2 >= 2", N_IN);
  end

  logic [SEL_W-1:0]            eff_sel;
  logic [SEL_W:0]              vld_pipe;
  logic [SEL_W:0][SEL_W-1:0]   tag_pipe;

  assign eff_sel     = scan_en ? scan_ptr : in_sel;
  assign vld_pipe[0] = in_valid;
  assign tag_pipe[0] = eff_sel;

  // Scan pointer advances only on accepted scan samples; natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  scan_ptr <= '0;
    else if (scan_en && in_valid) scan_ptr <= scan_ptr + SEL_W'(1);
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int IN_CNT = N_IN >> k;

    logic [IN_CNT-1:0][DATA_W-1:0]   vin;
    logic [IN_CNT/2-1:0][DATA_W-1:0] vout;

    if (k == 0) begin : g_src
      assign vin = in_data;
    end else begin : g_chain
      assign vin = g_lvl[k-1].vout;
    end

    mux_tree_stage #(
      .IN_CNT (IN_CNT),
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vec    (vin),
      .in_tag    (tag_pipe[k]),
      .in_valid  (vld_pipe[k]),
      .out_vec   (vout),
      .out_tag   (tag_pipe[k+1]),
      .out_valid (vld_pipe[k+1])
    );

    if (k == SEL_W-1) begin : g_out
      assign out_data = vout[0];
    end
  end

  assign out_sel   = tag_pipe[SEL_W];
  assign out_valid = vld_pipe[SEL_W];

endmodule
